dcpu16_mem: RTL

DCPU16_MEM -- requirements
Module: dcpu16_mem

---
 rtl/dcpu16_mem_pkg.sv | 13 +
 rtl/dcpu16_mem_port.sv | 90 +++++++++
 rtl/dcpu16_mem.sv | 83 ++++++++
 3 files changed

// File: rtl/dcpu16_mem_pkg.sv
// Shared types for the dual-port DCPU-16 memory: the port FSM states and the wait counter width.
// No logic.
package dcpu16_mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } port_state_t;

endpackage

// File: rtl/dcpu16_mem_port.sv
// One bus port: it captures the request and counts WAIT cycles, then pulses ack for one cycle (ack in cycle n+1+WAIT).
// Dropping stb during WAIT aborts the access. go marks the edge that enters ACK, where the top performs the access.
module dcpu16_mem_port
    import dcpu16_mem_pkg::*;
#(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int WAIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] dto,
    input  logic          stb,
    input  logic          wre,
    output logic          ack,
    output logic          go,
    output logic          go_wre,
    output logic [AW-1:0] go_adr,
    output logic [DW-1:0] go_dat
);

    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

    port_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    adr_q;
    logic [DW-1:0]    dat_q;
    logic             wre_q;
    logic             cap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            wre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                adr_q <= adr;
                dat_q <= dto;
                wre_q <= wre;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        go      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stb) begin
                    cap = 1'b1;
                    if (WAIT > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_ACK;
                        go      = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!stb) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    go      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait the capture and the access share one edge, so the live inputs are forwarded.
    assign go_adr = (state_q == ST_IDLE) ? adr : adr_q;
    assign go_dat = (state_q == ST_IDLE) ? dto : dat_q;
    assign go_wre = (state_q == ST_IDLE) ? wre : wre_q;
    assign ack    = (state_q == ST_ACK);

endmodule

// File: rtl/dcpu16_mem.sv
// Dual-port word memory with fetch (fs) and address-bus (ab) ports. Each port has its own wait-state FSM.
// Reads return old data when the other port writes the same word. If both ports write one word, ab wins.
module dcpu16_mem
    import dcpu16_mem_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int FS_WAIT = 0,
    parameter int AB_WAIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] fs_adr,
    input  logic [DW-1:0] fs_dto,
    input  logic          fs_stb,
    input  logic          fs_wre,
    output logic [DW-1:0] fs_dti,
    output logic          fs_ack,
    input  logic [AW-1:0] ab_adr,
    input  logic [DW-1:0] ab_dto,
    input  logic          ab_stb,
    input  logic          ab_wre,
    output logic [DW-1:0] ab_dti,
    output logic          ab_ack
);

    logic          fs_go, fs_go_wre, ab_go, ab_go_wre;
    logic [AW-1:0] fs_go_adr, ab_go_adr;
    logic [DW-1:0] fs_go_dat, ab_go_dat;

    logic [DW-1:0] mem [2**AW];

    dcpu16_mem_port #(.AW(AW), .DW(DW), .WAIT(FS_WAIT)) u_fs (
        .clk    (clk),
        .rst    (rst),
        .adr    (fs_adr),
        .dto    (fs_dto),
        .stb    (fs_stb),
        .wre    (fs_wre),
        .ack    (fs_ack),
        .go     (fs_go),
        .go_wre (fs_go_wre),
        .go_adr (fs_go_adr),
        .go_dat (fs_go_dat)
    );

    dcpu16_mem_port #(.AW(AW), .DW(DW), .WAIT(AB_WAIT)) u_ab (
        .clk    (clk),
        .rst    (rst),
        .adr    (ab_adr),
        .dto    (ab_dto),
        .stb    (ab_stb),
        .wre    (ab_wre),
        .ack    (ab_ack),
        .go     (ab_go),
        .go_wre (ab_go_wre),
        .go_adr (ab_go_adr),
        .go_dat (ab_go_dat)
    );

    // The memory has no reset. Writes are gated off while rst is low so that a held stb cannot write.
    // The ab write is listed last, so it lands when both ports write the same word.
    always_ff @(posedge clk) begin
        if (rst && fs_go && fs_go_wre)
            mem[fs_go_adr] <= fs_go_dat;
        if (rst && ab_go && ab_go_wre)
            mem[ab_go_adr] <= ab_go_dat;
    end

    // Non-blocking reads sample the array before this edge's writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fs_dti <= '0;
            ab_dti <= '0;
        end else begin
            if (fs_go && !fs_go_wre)
                fs_dti <= mem[fs_go_adr];
            if (ab_go && !ab_go_wre)
                ab_dti <= mem[ab_go_adr];
        end
    end

endmodule
